// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/writeback/redirect bundle between the pipeline stages and pipe_hazard_ctrl.
// The master drives the decode-stage view; the slave (the controller) returns issue/stall/flush/PC steering.
interface pipe_hazard_ctrl_if #(
  parameter int REGSZ  = 5,
  parameter int NREGS  = 32,
  parameter int WORDSZ = 64
);
  logic              dec_valid;
  logic [REGSZ-1:0]  dec_rs1;
  logic [REGSZ-1:0]  dec_rs2;
  logic              dec_use_rs1;
  logic              dec_use_rs2;
  logic [REGSZ-1:0]  dec_rd;
  logic              dec_wr_rd;
  logic              dec_is_load;
  logic              wb_valid;
  logic [REGSZ-1:0]  wb_rd;
  logic              ld_done;
  logic              redirect;
  logic [WORDSZ-1:0] redirect_pc;

  logic              issue;
  logic              stall_fetch;
  logic              stall_dec;
  logic              flush_dec;
  logic              pc_sel;
  logic [WORDSZ-1:0] pc_target;
  logic [NREGS-1:0]  busy_mask;
  logic [2:0]        ld_cnt;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd,
           dec_wr_rd, dec_is_load, wb_valid, wb_rd, ld_done, redirect, redirect_pc,
    input  issue, stall_fetch, stall_dec, flush_dec, pc_sel, pc_target, busy_mask, ld_cnt
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd,
           dec_wr_rd, dec_is_load, wb_valid, wb_rd, ld_done, redirect, redirect_pc,
    output issue, stall_fetch, stall_dec, flush_dec, pc_sel, pc_target, busy_mask, ld_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/issue control for the in-order pipeline: register scoreboard, load-slot tracking, redirect flush sequencing.
// Optional macro HAZ_WB_BYPASS_EN: a same-cycle writeback / ld_done frees the register / load slot for this cycle's decision.
module pipe_hazard_ctrl #(
  parameter int REGSZ     = 5,
  parameter int NREGS     = 32,
  parameter int WORDSZ    = 64,
  parameter int MAX_LD    = 1,
  parameter int FLUSH_CYC = 2
) (
  input logic              clk,
  input logic              reset,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state_q;
  logic [2:0]       flushCnt_q;
  logic [NREGS-1:0] sb_q, sb_d;
  logic [2:0]       ldCnt_q, ldCnt_d;

  logic [NREGS-1:0] busyVec;
  logic             ldFull;
  logic             hazard;
  logic             running;
  logic             issueW;
  logic             stallW;

  // Busy view used for the hazard decision; with bypass, a register retiring now is already readable.
  always_comb begin
    busyVec = sb_q;
    ldFull  = (ldCnt_q == 3'(MAX_LD));
`ifdef HAZ_WB_BYPASS_EN
    if (bus.wb_valid) busyVec[bus.wb_rd] = 1'b0;
    if (bus.ld_done)  ldFull = 1'b0;
`endif
    hazard  = (bus.dec_use_rs1 & busyVec[bus.dec_rs1])
            | (bus.dec_use_rs2 & busyVec[bus.dec_rs2])
            | (bus.dec_wr_rd   & busyVec[bus.dec_rd])
            | (bus.dec_is_load & ldFull);
    running = (state_q == RUN);
    issueW  = bus.dec_valid & ~hazard & running & ~bus.redirect;
    stallW  = bus.dec_valid &  hazard & running & ~bus.redirect;
  end

  assign bus.issue       = issueW;
  assign bus.stall_dec   = stallW;
  assign bus.stall_fetch = stallW;
  assign bus.flush_dec   = (running & bus.redirect) | ~running;
  assign bus.pc_sel      = running & bus.redirect;
  assign bus.pc_target   = (running & bus.redirect) ? bus.redirect_pc : '0;
  assign bus.busy_mask   = sb_q;
  assign bus.ld_cnt      = ldCnt_q;

  // Set is applied after clear so an issue to the register being retired keeps it busy.
  always_comb begin
    sb_d = sb_q;
    if (bus.wb_valid) sb_d[bus.wb_rd] = 1'b0;
    if (issueW && bus.dec_wr_rd && bus.dec_rd != '0) sb_d[bus.dec_rd] = 1'b1;
    sb_d[0] = 1'b0;

    ldCnt_d = ldCnt_q;
    if (bus.ld_done && ldCnt_q != 3'd0) ldCnt_d = ldCnt_d - 3'd1;
    if (issueW && bus.dec_is_load)      ldCnt_d = ldCnt_d + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q    <= '0;
      ldCnt_q <= 3'd0;
    end else begin
      sb_q    <= sb_d;
      ldCnt_q <= ldCnt_d;
    end
  end

  // Redirects seen while flushing are wrong-path and dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      flushCnt_q <= 3'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.redirect) begin
            state_q    <= FLUSH;
            flushCnt_q <= 3'(FLUSH_CYC);
          end
        end
        FLUSH: begin
          if (flushCnt_q <= 3'd1) begin
            state_q    <= RUN;
            flushCnt_q <= 3'd0;
          end else begin
            flushCnt_q <= flushCnt_q - 3'd1;
          end
        end
        default: begin
          state_q    <= RUN;
          flushCnt_q <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised scoreboard bench for pipe_hazard_ctrl: the driver pushes model predictions, a monitor compares each cycle.
// The reference model tracks pending writes, outstanding loads and remaining flush cycles as plain variables.
module tb_pipe_hazard_ctrl;
  localparam int REGSZ     = 5;
  localparam int NREGS     = 32;
  localparam int WORDSZ    = 64;
  localparam int MAX_LD    = 1;
  localparam int FLUSH_CYC = 2;

  typedef struct packed {
    logic              rst;
    logic              valid;
    logic [REGSZ-1:0]  rs1;
    logic [REGSZ-1:0]  rs2;
    logic              useRs1;
    logic              useRs2;
    logic [REGSZ-1:0]  rd;
    logic              wrRd;
    logic              isLoad;
    logic              wbValid;
    logic [REGSZ-1:0]  wbRd;
    logic              ldDone;
    logic              redirect;
    logic [WORDSZ-1:0] redirectPc;
  } stim_t;

  typedef struct packed {
    logic              check;
    logic              issue;
    logic              stall;
    logic              flush;
    logic              pcSel;
    logic [WORDSZ-1:0] pcTarget;
    logic [NREGS-1:0]  busyMask;
    logic [2:0]        ldCnt;
  } exp_t;

  logic clk;
  logic reset;
  pipe_hazard_ctrl_if #(.REGSZ(REGSZ), .NREGS(NREGS), .WORDSZ(WORDSZ)) bus ();

  pipe_hazard_ctrl #(
    .REGSZ(REGSZ), .NREGS(NREGS), .WORDSZ(WORDSZ), .MAX_LD(MAX_LD), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cycleNo = 0;

  bit   pending[NREGS];
  int   loadsOut;
  int   flushLeft;

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t randomStim();
    stim_t s;
    s            = '0;
    s.rst        = ($urandom_range(0, 299) == 0);
    s.valid      = ($urandom_range(0, 3) != 0);
    s.rs1        = REGSZ'($urandom_range(0, 7));
    s.rs2        = REGSZ'($urandom_range(0, 7));
    s.useRs1     = $urandom_range(0, 1) == 1;
    s.useRs2     = $urandom_range(0, 1) == 1;
    s.rd         = REGSZ'($urandom_range(0, 7));
    s.wrRd       = $urandom_range(0, 2) != 0;
    s.isLoad     = ($urandom_range(0, 2) == 0);
    s.wbValid    = ($urandom_range(0, 2) == 0);
    s.wbRd       = REGSZ'($urandom_range(0, 7));
    s.ldDone     = ($urandom_range(0, 3) == 0);
    s.redirect   = ($urandom_range(0, 15) == 0);
    s.redirectPc = {$urandom, $urandom};
    return s;
  endfunction

  function automatic bit isBusy(int r, stim_t s);
    if (r == 0) return 1'b0;
`ifdef HAZ_WB_BYPASS_EN
    if (s.wbValid && int'(s.wbRd) == r) return 1'b0;
`endif
    return pending[r];
  endfunction

  // Drive one cycle, record the predicted response, then advance the model past the coming edge.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    bit   loadBlocked, hazard, running, issue;
    @(posedge clk);
    #1;
    cycleNo++;
    reset               = s.rst;
    bus.dec_valid       = s.valid;
    bus.dec_rs1         = s.rs1;
    bus.dec_rs2         = s.rs2;
    bus.dec_use_rs1     = s.useRs1;
    bus.dec_use_rs2     = s.useRs2;
    bus.dec_rd          = s.rd;
    bus.dec_wr_rd       = s.wrRd;
    bus.dec_is_load     = s.isLoad;
    bus.wb_valid        = s.wbValid;
    bus.wb_rd           = s.wbRd;
    bus.ld_done         = s.ldDone;
    bus.redirect        = s.redirect;
    bus.redirect_pc     = s.redirectPc;

    loadBlocked = s.isLoad && (loadsOut == MAX_LD);
`ifdef HAZ_WB_BYPASS_EN
    if (s.ldDone) loadBlocked = 1'b0;
`endif
    hazard  = (s.useRs1 && isBusy(int'(s.rs1), s)) || (s.useRs2 && isBusy(int'(s.rs2), s))
           || (s.wrRd && isBusy(int'(s.rd), s)) || loadBlocked;
    running = (flushLeft == 0);
    issue   = s.valid && !hazard && running && !s.redirect;

    e.check    = !s.rst;
    e.issue    = issue;
    e.stall    = s.valid && hazard && running && !s.redirect;
    e.flush    = !running || s.redirect;
    e.pcSel    = running && s.redirect;
    e.pcTarget = (running && s.redirect) ? s.redirectPc : '0;
    e.busyMask = '0;
    for (int r = 0; r < NREGS; r++) e.busyMask[r] = pending[r];
    e.ldCnt    = 3'(loadsOut);
    expQ.push_back(e);

    if (s.rst) begin
      for (int r = 0; r < NREGS; r++) pending[r] = 1'b0;
      loadsOut  = 0;
      flushLeft = 0;
    end else begin
      if (s.wbValid) pending[int'(s.wbRd)] = 1'b0;
      if (issue && s.wrRd && s.rd != 0) pending[int'(s.rd)] = 1'b1;
      if (s.ldDone && loadsOut > 0) loadsOut--;
      if (issue && s.isLoad) loadsOut++;
      if (!running) flushLeft--;
      else if (s.redirect) flushLeft = FLUSH_CYC;
    end
  endtask

  task automatic compareField(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d actual %0h required %0h", name, cycleNo, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compareField("issue",       64'(bus.issue),       64'(e.issue));
    compareField("stall_dec",   64'(bus.stall_dec),   64'(e.stall));
    compareField("stall_fetch", 64'(bus.stall_fetch), 64'(e.stall));
    compareField("flush_dec",   64'(bus.flush_dec),   64'(e.flush));
    compareField("pc_sel",      64'(bus.pc_sel),      64'(e.pcSel));
    compareField("pc_target",   bus.pc_target,        e.pcTarget);
    compareField("busy_mask",   64'(bus.busy_mask),   64'(e.busyMask));
    compareField("ld_cnt",      64'(bus.ld_cnt),      64'(e.ldCnt));
  endtask

  // Monitor: the controller presents a response every cycle, so each popped prediction is compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        if (e.check) checkOutput(e);
      end
    end
  end

  initial begin
    stim_t s;
    reset = 1'b1;
    bus.dec_valid = 0; bus.dec_rs1 = 0; bus.dec_rs2 = 0; bus.dec_use_rs1 = 0; bus.dec_use_rs2 = 0;
    bus.dec_rd = 0; bus.dec_wr_rd = 0; bus.dec_is_load = 0; bus.wb_valid = 0; bus.wb_rd = 0;
    bus.ld_done = 0; bus.redirect = 0; bus.redirect_pc = 0;
    for (int r = 0; r < NREGS; r++) pending[r] = 1'b0;
    loadsOut = 0;
    flushLeft = 0;

    s = idleStim(); s.rst = 1'b1;
    repeat (2) applyStimulus(s);
    applyStimulus(idleStim());

    // Writer to r5, then a dependent reader held until r5 retires.
    s = idleStim(); s.valid = 1; s.rd = 5; s.wrRd = 1;
    applyStimulus(s);
    s = idleStim(); s.valid = 1; s.rs1 = 5; s.useRs1 = 1; s.rd = 6; s.wrRd = 1;
    repeat (3) applyStimulus(s);
    s.wbValid = 1; s.wbRd = 5;
    applyStimulus(s);
    s.wbValid = 0;
    repeat (2) applyStimulus(s);

    // r0 never becomes busy; same-cycle set and clear of r7 leaves it busy.
    s = idleStim(); s.valid = 1; s.rd = 0; s.wrRd = 1;
    applyStimulus(s);
    s = idleStim(); s.wbValid = 1; s.wbRd = 6;
    applyStimulus(s);
    s = idleStim(); s.valid = 1; s.rd = 7; s.wrRd = 1; s.wbValid = 1; s.wbRd = 7;
    applyStimulus(s);
    applyStimulus(idleStim());

    // Load slot pressure.
    s = idleStim(); s.valid = 1; s.isLoad = 1;
    repeat (3) applyStimulus(s);
    s.ldDone = 1;
    applyStimulus(s);
    s.ldDone = 0;
    repeat (2) applyStimulus(s);
    s = idleStim(); s.ldDone = 1;
    applyStimulus(s);

    // Redirect, a wrong-path redirect one cycle later, and issue resuming after the flush.
    s = idleStim(); s.valid = 1; s.redirect = 1; s.redirectPc = 64'h0000_0000_8000_0100;
    applyStimulus(s);
    s.redirectPc = 64'h0000_0000_8000_0200;
    applyStimulus(s);
    s.redirect = 0;
    repeat (3) applyStimulus(s);

    // Reset landing in the middle of a flush.
    s = idleStim(); s.redirect = 1; s.redirectPc = 64'h1234;
    applyStimulus(s);
    s = idleStim(); s.rst = 1;
    applyStimulus(s);
    repeat (2) applyStimulus(idleStim());

    for (int n = 0; n < 4000; n++) applyStimulus(randomStim());
    applyStimulus(idleStim());

    for (int w = 0; w < 10 && expQ.size() > 0; w++) @(posedge clk);
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain actual %0d pending required 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
